// File: rtl/pc_fetch_stage_pkg.sv
// Shared fetch-stage definitions: widths, ARMv8 NOP, PC increment and FSM encodings.
// Decode and hazard logic import this package as well.
package pc_fetch_stage_pkg;

    localparam int ADDR_W  = 64;
    localparam int INSTR_W = 32;
    localparam int BUB_W   = 3;

    localparam logic [ADDR_W-1:0]  PC_INC    = 64'd4;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'hD503_201F;

    typedef enum logic [1:0] {
        ST_BOOT     = 2'd0,
        ST_RUN      = 2'd1,
        ST_REDIRECT = 2'd2
    } fetch_state_t;

    // Instruction fetch addresses are always 4-byte aligned.
    function automatic logic [ADDR_W-1:0] align_word(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_fetch_stage_if.sv
// Fetch-stage boundary: hazard/redirect inputs, imem read data, IF/ID latch outputs.
// master = surrounding pipeline, slave = the fetch stage itself.
interface pc_fetch_stage_if;
    import pc_fetch_stage_pkg::*;

    logic                stall_i;
    logic                branch_taken_i;
    logic [ADDR_W-1:0]   branch_target_i;
    logic [INSTR_W-1:0]  instr_i;

    logic [ADDR_W-1:0]   imem_addr_o;
    logic [ADDR_W-1:0]   ifid_pc_o;
    logic [ADDR_W-1:0]   ifid_pc_plus4_o;
    logic [INSTR_W-1:0]  ifid_instr_o;
    logic                ifid_valid_o;
    logic                misalign_o;
    logic [31:0]         fetch_count_o;

    modport master (
        output stall_i,
        output branch_taken_i,
        output branch_target_i,
        output instr_i,
        input  imem_addr_o,
        input  ifid_pc_o,
        input  ifid_pc_plus4_o,
        input  ifid_instr_o,
        input  ifid_valid_o,
        input  misalign_o,
        input  fetch_count_o
    );

    modport slave (
        input  stall_i,
        input  branch_taken_i,
        input  branch_target_i,
        input  instr_i,
        output imem_addr_o,
        output ifid_pc_o,
        output ifid_pc_plus4_o,
        output ifid_instr_o,
        output ifid_valid_o,
        output misalign_o,
        output fetch_count_o
    );

endinterface

// File: rtl/pc_fetch_stage_adder.sv
// Chunked ripple adder used for pc+PC_INC; the sum wraps modulo 2^WIDTH with no carry out.
module pc_fetch_stage_adder #(
    parameter int WIDTH   = 64,
    parameter int CHUNK_W = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum
);

    localparam int N_CHUNK = WIDTH / CHUNK_W;

    logic [N_CHUNK-1:0] carry;

    assign carry[0] = 1'b0;

    genvar gi;
    generate
        for (gi = 0; gi < N_CHUNK; gi++) begin : g_chunk
            if (gi < N_CHUNK - 1) begin : g_mid
                assign {carry[gi+1], sum[gi*CHUNK_W +: CHUNK_W]} =
                    {1'b0, a[gi*CHUNK_W +: CHUNK_W]} +
                    {1'b0, b[gi*CHUNK_W +: CHUNK_W]} +
                    {{CHUNK_W{1'b0}}, carry[gi]};
            end else begin : g_top
                // Top chunk drops its carry so the PC wraps silently.
                assign sum[gi*CHUNK_W +: CHUNK_W] =
                    a[gi*CHUNK_W +: CHUNK_W] +
                    b[gi*CHUNK_W +: CHUNK_W] +
                    {{(CHUNK_W-1){1'b0}}, carry[gi]};
            end
        end
    endgenerate

endmodule

// File: rtl/pc_fetch_stage.sv
// Fetch stage: PC register, redirect/bubble control, IF/ID latch and fetch counter.
// Branch beats stall beats sequential advance; reset wins over all of them.
module pc_fetch_stage #(
    parameter logic [63:0] RESET_PC         = 64'h0,
    parameter logic [63:0] PC_INC           = pc_fetch_stage_pkg::PC_INC,
    parameter int unsigned REDIRECT_BUBBLES = 1,
    parameter logic [31:0] NOP_INSTR        = pc_fetch_stage_pkg::NOP_INSTR
) (
    input  logic              clk,
    input  logic              reset,
    pc_fetch_stage_if.slave   fetch
);

    import pc_fetch_stage_pkg::*;

    localparam logic [BUB_W-1:0] BUB_LOAD = BUB_W'(REDIRECT_BUBBLES);

    fetch_state_t         state_reg;
    logic [BUB_W-1:0]     bub_cnt_reg;
    logic [ADDR_W-1:0]    pc_reg;
    logic [ADDR_W-1:0]    pc_plus_inc;
    logic [ADDR_W-1:0]    ifid_pc_reg;
    logic [ADDR_W-1:0]    ifid_pc_plus4_reg;
    logic [INSTR_W-1:0]   ifid_instr_reg;
    logic                 ifid_valid_reg;
    logic                 misalign_reg;
    logic [31:0]          fetch_count_reg;

    pc_fetch_stage_adder #(
        .WIDTH   (ADDR_W),
        .CHUNK_W (16)
    ) u_adder (
        .a   (pc_reg),
        .b   (PC_INC),
        .sum (pc_plus_inc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg         <= ST_BOOT;
            bub_cnt_reg       <= '0;
            pc_reg            <= RESET_PC;
            ifid_pc_reg       <= '0;
            ifid_pc_plus4_reg <= '0;
            ifid_instr_reg    <= NOP_INSTR;
            ifid_valid_reg    <= 1'b0;
            misalign_reg      <= 1'b0;
            fetch_count_reg   <= '0;
        end else begin
            misalign_reg <= 1'b0;
            unique case (state_reg)
                ST_BOOT: begin
                    state_reg <= ST_RUN;
                end
                ST_RUN, ST_REDIRECT: begin
                    if (fetch.branch_taken_i) begin
                        // IF/ID pc fields keep their old contents; only valid/instr mark the bubble.
                        pc_reg         <= align_word(fetch.branch_target_i);
                        ifid_instr_reg <= NOP_INSTR;
                        ifid_valid_reg <= 1'b0;
                        misalign_reg   <= |fetch.branch_target_i[1:0];
                        if (REDIRECT_BUBBLES > 0) begin
                            bub_cnt_reg <= BUB_LOAD;
                            state_reg   <= ST_REDIRECT;
                        end else begin
                            state_reg   <= ST_RUN;
                        end
                    end else if (fetch.stall_i) begin
                        state_reg <= state_reg;
                    end else if (state_reg == ST_RUN) begin
                        pc_reg            <= pc_plus_inc;
                        ifid_pc_reg       <= pc_reg;
                        ifid_pc_plus4_reg <= pc_plus_inc;
                        ifid_instr_reg    <= fetch.instr_i;
                        ifid_valid_reg    <= 1'b1;
                        fetch_count_reg   <= fetch_count_reg + 32'd1;
                    end else begin
                        ifid_instr_reg <= NOP_INSTR;
                        ifid_valid_reg <= 1'b0;
                        bub_cnt_reg    <= bub_cnt_reg - 1'b1;
                        if (bub_cnt_reg == BUB_W'(1)) begin
                            state_reg <= ST_RUN;
                        end
                    end
                end
                default: begin
                    state_reg <= ST_BOOT;
                end
            endcase
        end
    end

    assign fetch.imem_addr_o     = pc_reg;
    assign fetch.ifid_pc_o       = ifid_pc_reg;
    assign fetch.ifid_pc_plus4_o = ifid_pc_plus4_reg;
    assign fetch.ifid_instr_o    = ifid_instr_reg;
    assign fetch.ifid_valid_o    = ifid_valid_reg;
    assign fetch.misalign_o      = misalign_reg;
    assign fetch.fetch_count_o   = fetch_count_reg;

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Bench for pc_fetch_stage: directed scenarios on two instances (default, and wrap-around
// reset PC with two redirect bubbles) followed by randomized traffic against a reference model.
module tb_pc_fetch_stage;
    import pc_fetch_stage_pkg::*;

    localparam logic [63:0] B_RESET_PC = 64'hFFFF_FFFF_FFFF_FFFC;
    localparam int          A_BUB      = 1;
    localparam int          B_BUB      = 2;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    pc_fetch_stage_if ifa ();
    pc_fetch_stage_if ifb ();

    pc_fetch_stage #(
        .RESET_PC         (64'h0),
        .PC_INC           (64'd4),
        .REDIRECT_BUBBLES (A_BUB),
        .NOP_INSTR        (32'hD503_201F)
    ) dut_a (
        .clk   (clk),
        .reset (rst_a),
        .fetch (ifa)
    );

    pc_fetch_stage #(
        .RESET_PC         (B_RESET_PC),
        .PC_INC           (64'd4),
        .REDIRECT_BUBBLES (B_BUB),
        .NOP_INSTR        (32'hD503_201F)
    ) dut_b (
        .clk   (clk),
        .reset (rst_b),
        .fetch (ifb)
    );

    // Instruction memory contents are a fixed function of the address.
    function automatic logic [31:0] instr_of(input logic [63:0] addr);
        return addr[31:0] ^ 32'h1357_9BDF ^ addr[63:32];
    endfunction

    assign ifa.instr_i = instr_of(ifa.imem_addr_o);
    assign ifb.instr_i = instr_of(ifb.imem_addr_o);

    // Reference model: "hold" = number of upcoming unstalled cycles that must produce bubbles.
    typedef struct {
        logic [63:0] pc;
        logic [63:0] ipc;
        logic [63:0] ip4;
        logic [31:0] instr;
        logic        valid;
        logic        mis;
        logic [31:0] cnt;
        bit          boot;
        int          hold;
    } mdl_t;

    mdl_t ma;
    mdl_t mb;

    function automatic mdl_t mstep(mdl_t m, bit rst, bit st, bit br, logic [63:0] tgt,
                                   logic [63:0] rpc, int nb);
        mdl_t n = m;
        if (rst) begin
            n.pc = rpc; n.ipc = 64'h0; n.ip4 = 64'h0; n.instr = 32'hD503_201F;
            n.valid = 1'b0; n.mis = 1'b0; n.cnt = 32'h0; n.boot = 1'b1; n.hold = 0;
            return n;
        end
        n.mis = 1'b0;
        if (m.boot) begin
            n.boot = 1'b0;
        end else if (br) begin
            n.pc    = tgt & ~64'h3;
            n.instr = 32'hD503_201F;
            n.valid = 1'b0;
            n.mis   = (tgt[1:0] != 2'b00);
            n.hold  = nb;
        end else if (st) begin
            n.hold = m.hold;
        end else if (m.hold > 0) begin
            n.instr = 32'hD503_201F;
            n.valid = 1'b0;
            n.hold  = m.hold - 1;
        end else begin
            n.ipc   = m.pc;
            n.ip4   = m.pc + 64'd4;
            n.instr = instr_of(m.pc);
            n.valid = 1'b1;
            n.pc    = m.pc + 64'd4;
            n.cnt   = m.cnt + 32'd1;
        end
        return n;
    endfunction

    function automatic logic [257:0] exp_of(mdl_t m);
        return {m.pc, m.ipc, m.ip4, m.instr, m.valid, m.mis, m.cnt};
    endfunction

    function automatic logic [257:0] obs_a();
        return {ifa.imem_addr_o, ifa.ifid_pc_o, ifa.ifid_pc_plus4_o, ifa.ifid_instr_o,
                ifa.ifid_valid_o, ifa.misalign_o, ifa.fetch_count_o};
    endfunction

    function automatic logic [257:0] obs_b();
        return {ifb.imem_addr_o, ifb.ifid_pc_o, ifb.ifid_pc_plus4_o, ifb.ifid_instr_o,
                ifb.ifid_valid_o, ifb.misalign_o, ifb.fetch_count_o};
    endfunction

    // One clock: drive both instances, take the edge, advance both models, settle.
    task automatic cyc(input bit ra, input bit sa, input bit ba, input logic [63:0] ta,
                       input bit rb, input bit sb, input bit bb, input logic [63:0] tgt_b);
        rst_a               = ra;
        ifa.stall_i         = sa;
        ifa.branch_taken_i  = ba;
        ifa.branch_target_i = ta;
        rst_b               = rb;
        ifb.stall_i         = sb;
        ifb.branch_taken_i  = bb;
        ifb.branch_target_i = tgt_b;
        @(posedge clk);
        ma = mstep(ma, ra, sa, ba, ta, 64'h0, A_BUB);
        mb = mstep(mb, rb, sb, bb, tgt_b, B_RESET_PC, B_BUB);
        #1;
        $display("cyc t=%0t a: pc=%h ifid=%h v=%b n=%0d | b: pc=%h ifid=%h v=%b n=%0d",
                 $time, ifa.imem_addr_o, ifa.ifid_pc_o, ifa.ifid_valid_o, ifa.fetch_count_o,
                 ifb.imem_addr_o, ifb.ifid_pc_o, ifb.ifid_valid_o, ifb.fetch_count_o);
    endtask

    task automatic test_reset();
        cyc(1, 0, 0, 64'h0, 1, 0, 0, 64'h0);
        cyc(1, 1, 1, 64'h55, 1, 1, 1, 64'h57);
        total++;
        if (obs_a() !== {64'h0, 64'h0, 64'h0, 32'hD503_201F, 1'b0, 1'b0, 32'h0}) begin
            bad++;
            $display("FAIL reset_a got=%h want=%h", obs_a(),
                     {64'h0, 64'h0, 64'h0, 32'hD503_201F, 1'b0, 1'b0, 32'h0});
        end
        total++;
        if (ifb.imem_addr_o !== B_RESET_PC || ifb.ifid_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_b got pc=%h v=%b want pc=%h v=0", ifb.imem_addr_o,
                     ifb.ifid_valid_o, B_RESET_PC);
        end
    endtask

    task automatic test_free_run();
        logic [63:0] p;
        cyc(0, 0, 0, 64'h0, 1, 0, 0, 64'h0);
        total++;
        if (ifa.imem_addr_o !== 64'h0 || ifa.ifid_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL boot_hold got pc=%h v=%b want pc=0 v=0", ifa.imem_addr_o,
                     ifa.ifid_valid_o);
        end
        for (int k = 0; k < 3; k++) begin
            p = 64'(4 * k);
            cyc(0, 0, 0, 64'h0, 1, 0, 0, 64'h0);
            total++;
            if ({ifa.ifid_pc_o, ifa.ifid_pc_plus4_o, ifa.ifid_instr_o, ifa.ifid_valid_o,
                 ifa.imem_addr_o, ifa.fetch_count_o} !==
                {p, p + 64'd4, instr_of(p), 1'b1, p + 64'd4, 32'(k + 1)}) begin
                bad++;
                $display("FAIL free_run%0d got ifid=%h instr=%h v=%b pc=%h n=%0d want ifid=%h n=%0d",
                         k, ifa.ifid_pc_o, ifa.ifid_instr_o, ifa.ifid_valid_o, ifa.imem_addr_o,
                         ifa.fetch_count_o, p, k + 1);
            end
        end
        cyc(0, 0, 0, 64'h0, 1, 0, 0, 64'h0);
    endtask

    task automatic test_stall();
        for (int k = 0; k < 3; k++) begin
            cyc(0, 1, 0, 64'h0, 1, 0, 0, 64'h0);
            total++;
            if (ifa.imem_addr_o !== 64'h10 || ifa.ifid_pc_o !== 64'hC ||
                ifa.ifid_valid_o !== 1'b1 || ifa.fetch_count_o !== 32'd4) begin
                bad++;
                $display("FAIL stall%0d got pc=%h ifid=%h v=%b n=%0d want pc=10 ifid=c v=1 n=4",
                         k, ifa.imem_addr_o, ifa.ifid_pc_o, ifa.ifid_valid_o, ifa.fetch_count_o);
            end
        end
        cyc(0, 0, 0, 64'h0, 1, 0, 0, 64'h0);
        total++;
        if (ifa.ifid_pc_o !== 64'h10 || ifa.imem_addr_o !== 64'h14 ||
            ifa.fetch_count_o !== 32'd5) begin
            bad++;
            $display("FAIL stall_resume got ifid=%h pc=%h n=%0d want ifid=10 pc=14 n=5",
                     ifa.ifid_pc_o, ifa.imem_addr_o, ifa.fetch_count_o);
        end
    endtask

    task automatic test_redirect();
        cyc(0, 0, 1, 64'h100, 1, 0, 0, 64'h0);
        total++;
        if ({ifa.imem_addr_o, ifa.ifid_pc_o, ifa.ifid_instr_o, ifa.ifid_valid_o,
             ifa.misalign_o, ifa.fetch_count_o} !==
            {64'h100, 64'h10, 32'hD503_201F, 1'b0, 1'b0, 32'd5}) begin
            bad++;
            $display("FAIL redirect_bub1 got pc=%h ifid=%h instr=%h v=%b m=%b n=%0d want pc=100 ifid=10 nop v=0",
                     ifa.imem_addr_o, ifa.ifid_pc_o, ifa.ifid_instr_o, ifa.ifid_valid_o,
                     ifa.misalign_o, ifa.fetch_count_o);
        end
        cyc(0, 0, 0, 64'h0, 1, 0, 0, 64'h0);
        total++;
        if (ifa.imem_addr_o !== 64'h100 || ifa.ifid_valid_o !== 1'b0 ||
            ifa.ifid_instr_o !== 32'hD503_201F) begin
            bad++;
            $display("FAIL redirect_bub2 got pc=%h v=%b instr=%h want pc=100 v=0 nop",
                     ifa.imem_addr_o, ifa.ifid_valid_o, ifa.ifid_instr_o);
        end
        cyc(0, 0, 0, 64'h0, 1, 0, 0, 64'h0);
        total++;
        if (ifa.ifid_pc_o !== 64'h100 || ifa.ifid_valid_o !== 1'b1 ||
            ifa.ifid_instr_o !== instr_of(64'h100) || ifa.imem_addr_o !== 64'h104 ||
            ifa.fetch_count_o !== 32'd6) begin
            bad++;
            $display("FAIL redirect_target got ifid=%h v=%b instr=%h pc=%h n=%0d want ifid=100 v=1 pc=104 n=6",
                     ifa.ifid_pc_o, ifa.ifid_valid_o, ifa.ifid_instr_o, ifa.imem_addr_o,
                     ifa.fetch_count_o);
        end
    endtask

    task automatic test_branch_stall();
        cyc(0, 1, 1, 64'h203, 1, 0, 0, 64'h0);
        total++;
        if (ifa.imem_addr_o !== 64'h200 || ifa.misalign_o !== 1'b1 ||
            ifa.ifid_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL br_stall got pc=%h m=%b v=%b want pc=200 m=1 v=0",
                     ifa.imem_addr_o, ifa.misalign_o, ifa.ifid_valid_o);
        end
        for (int k = 0; k < 3; k++) begin
            cyc(0, (k < 2), 0, 64'h0, 1, 0, 0, 64'h0);
            total++;
            if (ifa.misalign_o !== 1'b0 || ifa.ifid_valid_o !== 1'b0 ||
                ifa.imem_addr_o !== 64'h200) begin
                bad++;
                $display("FAIL br_stall_hold%0d got pc=%h m=%b v=%b want pc=200 m=0 v=0",
                         k, ifa.imem_addr_o, ifa.misalign_o, ifa.ifid_valid_o);
            end
        end
        cyc(0, 0, 0, 64'h0, 1, 0, 0, 64'h0);
        total++;
        if (ifa.ifid_pc_o !== 64'h200 || ifa.ifid_valid_o !== 1'b1 ||
            ifa.fetch_count_o !== 32'd7) begin
            bad++;
            $display("FAIL br_stall_target got ifid=%h v=%b n=%0d want ifid=200 v=1 n=7",
                     ifa.ifid_pc_o, ifa.ifid_valid_o, ifa.fetch_count_o);
        end
    endtask

    task automatic test_reset_mid();
        cyc(0, 0, 1, 64'h300, 1, 0, 0, 64'h0);
        cyc(1, 1, 0, 64'h0, 1, 0, 0, 64'h0);
        total++;
        if (obs_a() !== {64'h0, 64'h0, 64'h0, 32'hD503_201F, 1'b0, 1'b0, 32'h0}) begin
            bad++;
            $display("FAIL reset_mid got=%h want=%h", obs_a(),
                     {64'h0, 64'h0, 64'h0, 32'hD503_201F, 1'b0, 1'b0, 32'h0});
        end
        cyc(0, 0, 0, 64'h0, 1, 0, 0, 64'h0);
        total++;
        if (ifa.imem_addr_o !== 64'h0 || ifa.ifid_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_boot got pc=%h v=%b want pc=0 v=0",
                     ifa.imem_addr_o, ifa.ifid_valid_o);
        end
        cyc(0, 0, 0, 64'h0, 1, 0, 0, 64'h0);
        total++;
        if (ifa.ifid_pc_o !== 64'h0 || ifa.ifid_valid_o !== 1'b1 ||
            ifa.fetch_count_o !== 32'd1) begin
            bad++;
            $display("FAIL reset_mid_run got ifid=%h v=%b n=%0d want ifid=0 v=1 n=1",
                     ifa.ifid_pc_o, ifa.ifid_valid_o, ifa.fetch_count_o);
        end
    endtask

    task automatic test_wrap_reload();
        cyc(0, 0, 0, 64'h0, 0, 0, 0, 64'h0);
        total++;
        if (ifb.imem_addr_o !== B_RESET_PC || ifb.ifid_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL wrap_boot got pc=%h v=%b want pc=%h v=0", ifb.imem_addr_o,
                     ifb.ifid_valid_o, B_RESET_PC);
        end
        cyc(0, 0, 0, 64'h0, 0, 0, 0, 64'h0);
        total++;
        if (ifb.ifid_pc_o !== B_RESET_PC || ifb.ifid_pc_plus4_o !== 64'h0 ||
            ifb.imem_addr_o !== 64'h0 || ifb.ifid_valid_o !== 1'b1) begin
            bad++;
            $display("FAIL wrap_add got ifid=%h p4=%h pc=%h v=%b want ifid=%h p4=0 pc=0 v=1",
                     ifb.ifid_pc_o, ifb.ifid_pc_plus4_o, ifb.imem_addr_o, ifb.ifid_valid_o,
                     B_RESET_PC);
        end
        cyc(0, 0, 0, 64'h0, 0, 0, 1, 64'h80);
        cyc(0, 0, 0, 64'h0, 0, 0, 1, 64'h40);
        total++;
        if (ifb.imem_addr_o !== 64'h40 || ifb.ifid_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL reload_pc got pc=%h v=%b want pc=40 v=0", ifb.imem_addr_o,
                     ifb.ifid_valid_o);
        end
        for (int k = 0; k < 2; k++) begin
            cyc(0, 0, 0, 64'h0, 0, 0, 0, 64'h0);
            total++;
            if (ifb.ifid_valid_o !== 1'b0 || ifb.imem_addr_o !== 64'h40) begin
                bad++;
                $display("FAIL reload_bub%0d got pc=%h v=%b want pc=40 v=0", k,
                         ifb.imem_addr_o, ifb.ifid_valid_o);
            end
        end
        cyc(0, 0, 0, 64'h0, 0, 0, 0, 64'h0);
        total++;
        if (ifb.ifid_pc_o !== 64'h40 || ifb.ifid_valid_o !== 1'b1 ||
            ifb.ifid_instr_o !== instr_of(64'h40)) begin
            bad++;
            $display("FAIL reload_target got ifid=%h v=%b instr=%h want ifid=40 v=1",
                     ifb.ifid_pc_o, ifb.ifid_valid_o, ifb.ifid_instr_o);
        end
    endtask

    task automatic test_random();
        bit          ra, sa, ba, rb, sb, bb;
        logic [63:0] ta, tgt_b;
        for (int i = 0; i < 600; i++) begin
            ra = ($urandom_range(0, 127) == 0);
            rb = ($urandom_range(0, 127) == 0);
            sa = ($urandom_range(0, 3) == 0);
            sb = ($urandom_range(0, 3) == 0);
            ba = ($urandom_range(0, 9) == 0);
            bb = ($urandom_range(0, 9) == 0);
            ta    = {32'h0, $urandom_range(0, 32'hFFFF)};
            tgt_b = ($urandom_range(0, 1) == 1) ? 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15))
                                                : {$urandom, $urandom};
            cyc(ra, sa, ba, ta, rb, sb, bb, tgt_b);
            total++;
            if (obs_a() !== exp_of(ma)) begin
                bad++;
                $display("FAIL rand_a[%0d] got=%h want=%h", i, obs_a(), exp_of(ma));
            end
            total++;
            if (obs_b() !== exp_of(mb)) begin
                bad++;
                $display("FAIL rand_b[%0d] got=%h want=%h", i, obs_b(), exp_of(mb));
            end
        end
    endtask

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        ifa.stall_i = 1'b0; ifa.branch_taken_i = 1'b0; ifa.branch_target_i = 64'h0;
        ifb.stall_i = 1'b0; ifb.branch_taken_i = 1'b0; ifb.branch_target_i = 64'h0;
        test_reset();
        test_free_run();
        test_stall();
        test_redirect();
        test_branch_stall();
        test_reset_mid();
        test_wrap_reload();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
